frontend_repl_ctrl: RTL and testbench
=====================================

// Module: frontend_repl_ctrl
// PURPOSE
//  Replacement/invalidation scheduler for a set-associative frontend predictor table.
//  Owns a free-running shift-register random source and picks a victim way per fill request:
//  the lowest-index invalid way if one exists, else a pseudo-random way.
//  Sequences a full-table invalidation sweep on flush. The table write port is the grant consumer.
// PARAMETERS
//  NR_WAYS    4   ways per set; power of 2, >=2; WAY_W = $clog2(NR_WAYS)
//  NR_SETS    64  sets in table; power of 2, >=2; SET_W = $clog2(NR_SETS)
//  LFSR_WIDTH 8   random-source width; must be >= WAY_W+1
// PORTS
//  clk_i         in   1        clock
//  rst_ni        in   1        reset, asynchronous, active-low
//  flush_i       in   1        request full-table invalidation sweep (pulse or level)
//  req_valid_i   in   1        fill request valid
//  req_ready_o   out  1        fill request accepted when valid&ready
//  req_set_i     in   SET_W    set index of fill
//  valid_ways_i  in   NR_WAYS  per-way valid bits of req_set_i, sampled on accept
//  grant_valid_o out  1        write command valid
//  grant_ready_i in   1        write command consumed
//  grant_set_o   out  SET_W    set to write
//  grant_way_o   out  WAY_W    victim way (0 for invalidation commands)
//  grant_inv_o   out  1        1: invalidate all ways of grant_set_o; 0: fill grant_way_o
//  busy_o        out  1        state != IDLE or flush pending
// BEHAVIOUR
//  Random source: lfsr_q[LFSR_WIDTH], reset 1; every cycle
//   lfsr_q <= {lfsr_q[W-2:0], lfsr_q[W-1]^lfsr_q[W-2]}; rand_way = lfsr_q[W-1 -: WAY_W].
//   Free-running; not gated by any state or handshake.
//  FSM states IDLE, GRANT, FLUSH. Reset: IDLE, set counter 0, flush_pend_q 0,
//   grant_valid_o 0, grant_set_o/grant_way_o/grant_inv_o 0, busy_o 0.
//  req_ready_o = (state==IDLE) & ~flush_pend_q & ~flush_i (combinational; 1 out of reset).
//  IDLE: flush_i | flush_pend_q -> FLUSH (counter 0, pend cleared). flush has priority over
//   req in the same cycle; the req is not accepted.
//   Else req_valid_i&req_ready_o -> register set=req_set_i, inv=0,
//   way = lowest-index 0 bit of valid_ways_i, or rand_way (lfsr_q of the accept cycle) if all 1
//   -> GRANT. grant_valid_o rises the cycle after accept (1-cycle latency).
//  GRANT: grant_valid_o=1; set/way/inv held stable until grant_ready_i; on handshake -> IDLE.
//   No new request accepted in GRANT; minimum spacing between accepts is 2 cycles.
//  FLUSH: grant_valid_o=1, inv=1, way=0, set=counter. On handshake counter+1; handshake with
//   counter==NR_SETS-1 -> IDLE, counter wraps to 0. Exactly NR_SETS commands per sweep.
//  flush_i seen in GRANT or FLUSH sets flush_pend_q; pending grant always completes first;
//   flush during FLUSH causes one further complete sweep after the current one (no restart).
//  grant_valid_o never drops without grant_ready_i (except reset).
//  Reset mid-operation: immediate return to reset values; pending grant/sweep discarded.
// TESTING
//  Reset, req set=5 valid_ways=4'b1011 -> next cycle grant_valid=1 set=5 way=2 inv=0.
//  All ways valid, req accepted when lfsr_q=0x40 (7th cycle after reset release) -> way=1;
//   grant_ready low 3 cycles -> outputs stable; valid_ways=0 -> way=0.
//  grant_ready held 0, req_valid held 1 -> req_ready_o=0 throughout, single grant only.
//  NR_SETS=4, flush_i pulse in IDLE -> grants set 0,1,2,3 inv=1, then busy_o=0, req_ready_o=1.
//  flush_i with req_valid in IDLE -> req not accepted, sweep runs; flush in GRANT -> grant
//   completes, then sweep.
//  rst_ni low mid-sweep -> all outputs 0, lfsr_q=1; after release normal req accepted.

Source files
------------

// File: rtl/frontend_repl_ctrl.sv
// frontend_repl_ctrl
//  Victim-way picker and invalidation sequencer for a set-associative frontend
//  predictor table. A fill request gets the lowest-index invalid way, or a
//  pseudo-random way from a free-running LFSR when every way is valid. A flush
//  walks every set once and issues one invalidate-all-ways command per set.
//  Commands go out on a valid/ready port that the table write port consumes.
// Ports
//  clk_i, rst_ni               clock, async active-low reset
//  flush_i                     request a full-table invalidation sweep
//  req_valid_i/req_ready_o     fill request handshake
//  req_set_i, valid_ways_i     set of the fill, and that set's per-way valid bits
//  grant_valid_o/grant_ready_i write command handshake
//  grant_set_o, grant_way_o    target set/way (way is 0 for invalidations)
//  grant_inv_o                 1: invalidate whole set, 0: fill one way
//  busy_o                      command outstanding or flush pending
module frontend_repl_ctrl #(
  parameter int NR_WAYS    = 4,
  parameter int NR_SETS    = 64,
  parameter int LFSR_WIDTH = 8,
  localparam int WAY_W = $clog2(NR_WAYS),
  localparam int SET_W = $clog2(NR_SETS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [SET_W-1:0]   req_set_i,
  input  logic [NR_WAYS-1:0] valid_ways_i,
  output logic               grant_valid_o,
  input  logic               grant_ready_i,
  output logic [SET_W-1:0]   grant_set_o,
  output logic [WAY_W-1:0]   grant_way_o,
  output logic               grant_inv_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [SET_W-1:0]      cnt_q, cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [SET_W-1:0]      set_q, set_d;
  logic [WAY_W-1:0]      way_q, way_d;

  logic [WAY_W-1:0] free_way;
  logic             all_valid;
  logic             grant_hs;

  // Free-running source: advances every cycle regardless of traffic.
  assign lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], lfsr_q[LFSR_WIDTH-1] ^ lfsr_q[LFSR_WIDTH-2]};

  // Lowest-index invalid way; scanning downward lets the lowest index win.
  always_comb begin
    free_way = '0;
    for (int i = NR_WAYS-1; i >= 0; i--) begin
      if (!valid_ways_i[i]) free_way = WAY_W'(i);
    end
  end
  assign all_valid = &valid_ways_i;

  assign req_ready_o   = (state_q == IDLE) & ~flush_pend_q & ~flush_i;
  assign grant_valid_o = (state_q != IDLE);
  assign grant_inv_o   = (state_q == FLUSH);
  assign grant_set_o   = (state_q == FLUSH) ? cnt_q : set_q;
  assign grant_way_o   = (state_q == FLUSH) ? '0 : way_q;
  assign busy_o        = (state_q != IDLE) | flush_pend_q;
  assign grant_hs      = grant_valid_o & grant_ready_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    set_d        = set_q;
    way_d        = way_q;
    unique case (state_q)
      IDLE: begin
        // Flush wins over a same-cycle request (req_ready_o is low then).
        if (flush_i || flush_pend_q) begin
          state_d      = FLUSH;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (req_valid_i && req_ready_o) begin
          state_d = GRANT;
          set_d   = req_set_i;
          way_d   = all_valid ? lfsr_q[LFSR_WIDTH-1 -: WAY_W] : free_way;
        end
      end
      GRANT: begin
        // A flush here is remembered; the grant in flight finishes first.
        if (flush_i) flush_pend_d = 1'b1;
        if (grant_hs) state_d = IDLE;
      end
      FLUSH: begin
        // A flush during a sweep queues one more full sweep, no restart.
        if (flush_i) flush_pend_d = 1'b1;
        if (grant_hs) begin
          if (cnt_q == SET_W'(NR_SETS-1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      lfsr_q       <= LFSR_WIDTH'(1);
      set_q        <= '0;
      way_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      lfsr_q       <= lfsr_d;
      set_q        <= set_d;
      way_q        <= way_d;
    end
  end

endmodule

// File: tb/tb_frontend_repl_ctrl.sv
// tb_frontend_repl_ctrl
//  Directed bench: fills with free and all-valid sets, grant stalls,
//  back-pressure on requests, flush sweeps (IDLE, GRANT, with a competing
//  request) and reset in the middle of a sweep. 8 sets keep sweeps short
//  while still holding set index 5.
module tb_frontend_repl_ctrl;
  localparam int NW = 4;
  localparam int NS = 8;
  localparam int WW = $clog2(NW);
  localparam int SW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_set;
  logic [NW-1:0] valid_ways;
  logic          grant_valid;
  logic          grant_ready;
  logic [SW-1:0] grant_set;
  logic [WW-1:0] grant_way;
  logic          grant_inv;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  frontend_repl_ctrl #(.NR_WAYS(NW), .NR_SETS(NS), .LFSR_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_set_i(req_set), .valid_ways_i(valid_ways),
    .grant_valid_o(grant_valid), .grant_ready_i(grant_ready),
    .grant_set_o(grant_set), .grant_way_o(grant_way),
    .grant_inv_o(grant_inv), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the sweep's invalidate commands one per cycle (grant_ready held 1).
  task automatic run_sweep(input string tag);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk); #1;
      chk({tag, "_valid"}, grant_valid, 1);
      chk({tag, "_inv"},   grant_inv,   1);
      chk({tag, "_way"},   grant_way,   0);
      chk({tag, "_set"},   grant_set,   i);
    end
    @(negedge clk); #1;
    chk({tag, "_done_valid"}, grant_valid, 0);
    chk({tag, "_done_busy"},  busy,        0);
    chk({tag, "_done_ready"}, req_ready,   1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_set = '0;
    valid_ways = '0; grant_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_set",    grant_set,   0);
    chk("rst_way",    grant_way,   0);
    chk("rst_inv",    grant_inv,   0);
    chk("rst_busy",   busy,        0);
    chk("rst_rdy",    req_ready,   1);
    chk("rst_lfsr",   dut.lfsr_q,  8'h01);
    rst_n = 1'b1;

    // Fill with free ways: lowest invalid of 1011 is way 2
    @(negedge clk);
    req_valid = 1'b1; req_set = 3'd5; valid_ways = 4'b1011; #1;
    chk("f1_rdy", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; grant_ready = 1'b1; #1;
    chk("f1_gvalid", grant_valid, 1);
    chk("f1_set",    grant_set,   5);
    chk("f1_way",    grant_way,   2);
    chk("f1_inv",    grant_inv,   0);
    chk("f1_rdy_g",  req_ready,   0);
    @(negedge clk);
    grant_ready = 1'b0; #1;
    chk("f1_idle",     grant_valid, 0);
    chk("f1_idle_rdy", req_ready,   1);

    // All ways valid: LFSR 0x40 at accept -> way 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    chk("r_lfsr", dut.lfsr_q, 8'h40);
    req_valid = 1'b1; req_set = 3'd3; valid_ways = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0; #1;
    chk("r_way", grant_way, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("r_stall_valid", grant_valid, 1);
      chk("r_stall_set",   grant_set,   3);
      chk("r_stall_way",   grant_way,   1);
    end
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0; #1;
    chk("r_idle", grant_valid, 0);

    // No valid ways -> way 0; request held under back-pressure
    req_valid = 1'b1; req_set = 3'd7; valid_ways = 4'b0000;
    @(negedge clk); #1;
    chk("z_way", grant_way, 0);
    chk("z_set", grant_set, 7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bp_rdy",    req_ready,   0);
      chk("bp_gvalid", grant_valid, 1);
      chk("bp_set",    grant_set,   7);
    end
    req_valid = 1'b0; grant_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_idle", grant_valid, 0);

    // Flush with a competing request in IDLE: request refused, sweep runs
    flush = 1'b1; req_valid = 1'b1; req_set = 3'd2; valid_ways = 4'b0000; #1;
    chk("fl_rdy", req_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    run_sweep("fl");

    // Flush while a fill grant is outstanding: grant first, then sweep
    grant_ready = 1'b0;
    req_valid = 1'b1; req_set = 3'd4; valid_ways = 4'b0001;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1; #1;
    chk("fg_inv",  grant_inv, 0);
    chk("fg_way",  grant_way, 1);
    @(negedge clk);
    flush = 1'b0; #1;
    chk("fg_hold_valid", grant_valid, 1);
    chk("fg_hold_set",   grant_set,   4);
    chk("fg_hold_inv",   grant_inv,   0);
    chk("fg_busy",       busy,        1);
    grant_ready = 1'b1;
    @(negedge clk); #1;
    chk("fg_pend_valid", grant_valid, 0);
    chk("fg_pend_busy",  busy,        1);
    chk("fg_pend_rdy",   req_ready,   0);
    run_sweep("fg");

    // Reset in the middle of a sweep
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mr_gvalid", grant_valid, 0);
    chk("mr_set",    grant_set,   0);
    chk("mr_inv",    grant_inv,   0);
    chk("mr_busy",   busy,        0);
    chk("mr_lfsr",   dut.lfsr_q,  8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; req_set = 3'd6; valid_ways = 4'b0111;
    @(negedge clk);
    req_valid = 1'b0; #1;
    chk("mr_fill_valid", grant_valid, 1);
    chk("mr_fill_set",   grant_set,   6);
    chk("mr_fill_way",   grant_way,   3);
    chk("mr_fill_inv",   grant_inv,   0);
    @(negedge clk); #1;
    chk("mr_fill_idle", grant_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
